// File: rtl/irq_scheduler_pkg.sv
// irq_pkg: shared definitions for the interrupt scheduler.
//   irq_state_t : scheduler states (IDLE, REQ, ACK)
//   OP_*        : i8080 opcodes placed on the bus during acknowledge
//   SRC_*       : bit index of each source in the pending vector
//   src_opcode  : RST opcode for a source index
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } irq_state_t;

  localparam logic [7:0] OP_RST1 = 8'hCF;  // RST 1, mid_screen
  localparam logic [7:0] OP_RST2 = 8'hD7;  // RST 2, vblank
  localparam logic [7:0] OP_NOP  = 8'h00;

  localparam int SRC_MID = 0;
  localparam int SRC_VBL = 1;

  function automatic logic [7:0] src_opcode(input logic src);
    return src ? OP_RST2 : OP_RST1;
  endfunction

endpackage

// File: rtl/irq_scheduler_if.sv
// irq_scheduler_if: CPU-side interrupt bus of the scheduler.
//   ack       : interrupt-acknowledge read (dbin & inta), driven by the CPU side
//   iint      : interrupt request to the CPU
//   vector    : opcode for the data bus during acknowledge
//   vector_oe : drive enable for vector (bus goes to Z when 0)
// Modports: master = CPU side, slave = scheduler side.
interface irq_scheduler_if #(
  parameter int XLEN = 8
);
  logic            ack;
  logic            iint;
  logic [XLEN-1:0] vector;
  logic            vector_oe;

  modport master (output ack, input iint, input vector, input vector_oe);
  modport slave  (input ack, output iint, output vector, output vector_oe);
endinterface

// File: rtl/irq_scheduler_sync_edge.sv
// sync_edge: SYNC_STAGES-deep synchronizer followed by a rising-edge detector.
//   clk      : destination clock
//   rst      : synchronous active-low reset, clears all history
//   async_in : asynchronous level input
//   rise     : one-cycle pulse when the synchronized level goes 0 -> 1
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/irq_scheduler.sv
// irq_scheduler: turns mid_screen / vblank strobes into i8080 RST interrupts.
//   clk, rst   : CPU clock; synchronous active-low reset
//   mid_screen : async level, rising edge requests RST 1
//   vblank     : async level, rising edge requests RST 2 (higher priority)
//   cpu        : iint / ack / vector / vector_oe bus (slave modport)
//   pending    : {vblank, mid_screen} pending flags
//   overrun    : saturating count of events lost while already pending
module irq_scheduler
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int XLEN        = 8,
  parameter int OVR_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mid_screen,
  input  logic                 vblank,
  irq_scheduler_if.slave       cpu,
  output logic [1:0]           pending,
  output logic [OVR_WIDTH-1:0] overrun
);

  logic [1:0] strobe;
  logic [1:0] rise_det;

  assign strobe = {vblank, mid_screen};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (strobe[gi]),
        .rise     (rise_det[gi])
      );
    end
  endgenerate

  irq_state_t           state_reg, state_next;
  logic [1:0]           pending_reg, pending_next;
  logic                 sel_reg, sel_next;
  logic [OVR_WIDTH-1:0] overrun_reg, overrun_next;
  logic                 iint_reg;

  logic [1:0]           clr;
  logic [1:0]           drop;
  logic [7:0]           vec_op;
  logic [OVR_WIDTH:0]   ovr_sum;

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    clr        = 2'b00;
    vec_op     = OP_NOP;  // IDLE: an ack here is spurious and reads a NOP

    case (state_reg)
      IDLE: begin
        if ((|pending_reg) || (|rise_det)) state_next = REQ;
      end
      REQ: begin
        vec_op = src_opcode(pending_reg[SRC_VBL]);
        if (cpu.ack) begin
          state_next = ACK;
          sel_next   = pending_reg[SRC_VBL];
        end
      end
      ACK: begin
        // Latched source keeps the opcode stable even if vblank arrives mid-read.
        vec_op = src_opcode(sel_reg);
        if (!cpu.ack) begin
          clr[sel_reg] = 1'b1;
          if (pending_reg[~sel_reg] || (|rise_det)) state_next = REQ;
          else                                      state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A new edge on the bit being cleared re-arms it instead of counting as lost.
    drop         = rise_det & pending_reg & ~clr;
    pending_next = (pending_reg & ~clr) | rise_det;

    ovr_sum      = {1'b0, overrun_reg} + (OVR_WIDTH+1)'(drop[0]) + (OVR_WIDTH+1)'(drop[1]);
    overrun_next = ovr_sum[OVR_WIDTH] ? '1 : ovr_sum[OVR_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      pending_reg <= 2'b00;
      sel_reg     <= 1'b0;
      overrun_reg <= '0;
      iint_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      sel_reg     <= sel_next;
      overrun_reg <= overrun_next;
      iint_reg    <= (state_next == REQ);
    end
  end

  assign cpu.iint      = iint_reg;
  assign cpu.vector    = XLEN'(vec_op);
  assign cpu.vector_oe = cpu.ack;
  assign pending       = pending_reg;
  assign overrun       = overrun_reg;

endmodule

// File: tb/tb_irq_scheduler.sv
module tb_irq_scheduler;

  localparam int S    = 2;
  localparam int XLEN = 8;
  localparam int OW   = 8;
  localparam int OVR_MAX = (1 << OW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mid_screen = 1'b0;
  logic          vblank = 1'b0;
  logic [1:0]    pending;
  logic [OW-1:0] overrun;

  irq_scheduler_if #(.XLEN(XLEN)) bus();

  irq_scheduler #(.SYNC_STAGES(S), .XLEN(XLEN), .OVR_WIDTH(OW)) dut (
    .clk        (clk),
    .rst        (rst),
    .mid_screen (mid_screen),
    .vblank     (vblank),
    .cpu        (bus),
    .pending    (pending),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- reference model ----------------
  // Levels reach the scheduler S cycles late; a request is outstanding until
  // the acknowledge read that serves it completes.
  logic [1:0] m_pend = 2'b00;
  logic       m_busy = 1'b0;
  logic       m_sel  = 1'b0;
  int         m_ovr  = 0;
  int         vh[$];
  int         mh[$];
  logic [1:0] m_ev, m_clr;

  always @(posedge clk) begin
    if (!rst) begin
      m_pend = 2'b00; m_busy = 1'b0; m_sel = 1'b0; m_ovr = 0;
      vh = {}; mh = {};
      for (int i = 0; i <= S; i++) begin vh.push_back(0); mh.push_back(0); end
    end else begin
      m_ev[1] = (vh[S-1] == 1) && (vh[S] == 0);
      m_ev[0] = (mh[S-1] == 1) && (mh[S] == 0);
      m_clr = 2'b00;
      if (m_busy && !bus.ack) begin
        m_clr[m_sel] = 1'b1;
        m_busy = 1'b0;
      end else if (!m_busy && bus.ack && m_pend != 2'b00) begin
        m_busy = 1'b1;
        m_sel  = m_pend[1];
      end
      for (int s = 0; s < 2; s++)
        if (m_ev[s] && m_pend[s] && !m_clr[s] && m_ovr < OVR_MAX) m_ovr++;
      m_pend = (m_pend & ~m_clr) | m_ev;
      vh.push_front(int'(vblank));     void'(vh.pop_back());
      mh.push_front(int'(mid_screen)); void'(mh.pop_back());
    end
  end

  function automatic logic [7:0] exp_vec();
    if (m_busy) return m_sel ? 8'hD7 : 8'hCF;
    if (m_pend[1]) return 8'hD7;
    if (m_pend[0]) return 8'hCF;
    return 8'h00;
  endfunction

  // ---------------- scoreboard + stimulus helpers ----------------
  logic [7:0] exp_q[$];
  bit         cpu_auto = 1'b0;
  int         ack_left = 0;

  task automatic cycle(input bit a);
    @(negedge clk);
    if (cpu_auto) begin
      if (ack_left > 0) begin
        a = 1'b1; ack_left--;
      end else if (bus.iint && $urandom_range(0, 2) == 0) begin
        a = 1'b1; ack_left = $urandom_range(0, 2);
      end else if (!bus.iint && $urandom_range(0, 39) == 0) begin
        a = 1'b1;
      end else begin
        a = 1'b0;
      end
    end
    bus.ack = a;
    if (a) exp_q.push_back(exp_vec());
  endtask

  task automatic wait_iint(input string name);
    int n;
    for (n = 0; n < 30; n++) begin
      if (bus.iint) break;
      cycle(1'b0);
    end
    tests++;
    if (!bus.iint) begin
      fails++;
      $display("[TB] FAIL %s: iint never rose within 30 cycles (got %b, need 1)", name, bus.iint);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [7:0] ev;
    forever begin
      @(negedge clk);
      #2;
      tests++;
      if (bus.iint !== (!m_busy && m_pend != 2'b00)) begin
        fails++;
        $display("[TB] FAIL iint t=%0t: got %b need %b", $time, bus.iint, (!m_busy && m_pend != 2'b00));
      end
      tests++;
      if (pending !== m_pend) begin
        fails++;
        $display("[TB] FAIL pending t=%0t: got %b need %b", $time, pending, m_pend);
      end
      tests++;
      if (overrun !== OW'(m_ovr)) begin
        fails++;
        $display("[TB] FAIL overrun t=%0t: got %0d need %0d", $time, overrun, m_ovr);
      end
      if (exp_q.size() > 0 || bus.vector_oe) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL vector_oe t=%0t: got 1 with no ack, need 0", $time);
        end else begin
          ev = exp_q.pop_front();
          if (bus.vector_oe !== 1'b1 || bus.vector !== ev) begin
            fails++;
            $display("[TB] FAIL ack_vector t=%0t: got oe=%b vector=%h need oe=1 vector=%h",
                     $time, bus.vector_oe, bus.vector, ev);
          end else begin
            $display("[TB] ack t=%0t vector=%h", $time, bus.vector);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bus.ack = 1'b0;

    // Reset held while strobes toggle.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0);
      vblank = ~vblank;
      mid_screen = (i % 3 == 0);
    end
    vblank = 1'b0; mid_screen = 1'b0;
    repeat (S + 2) cycle(1'b0);
    rst = 1'b1;
    repeat (4) cycle(1'b0);

    // Single vblank: latency, then a 2-cycle ack.
    vblank = 1'b1;
    for (n = 1; n <= 20; n++) begin
      cycle(1'b0);
      if (n == 2) vblank = 1'b0;
      if (bus.iint) break;
    end
    tests++;
    if (n != S + 1) begin
      fails++;
      $display("[TB] FAIL vblank_latency: got %0d cycles need %0d", n, S + 1);
    end
    cycle(1'b1); cycle(1'b1); cycle(1'b0);
    repeat (4) cycle(1'b0);

    // Simultaneous edges: vblank served first, then mid_screen.
    vblank = 1'b1; mid_screen = 1'b1;
    wait_iint("simul_first");
    vblank = 1'b0; mid_screen = 1'b0;
    cycle(1'b1); cycle(1'b1); cycle(1'b0);
    wait_iint("simul_second");
    cycle(1'b1); cycle(1'b0);
    repeat (4) cycle(1'b0);

    // Overrun: two mid_screen pulses before any ack.
    mid_screen = 1'b1; repeat (2) cycle(1'b0);
    mid_screen = 1'b0; repeat (2) cycle(1'b0);
    mid_screen = 1'b1; repeat (2) cycle(1'b0);
    mid_screen = 1'b0; repeat (S + 3) cycle(1'b0);
    cycle(1'b1); cycle(1'b0);
    repeat (4) cycle(1'b0);

    // Spurious ack in IDLE.
    cycle(1'b1); cycle(1'b0);
    repeat (3) cycle(1'b0);

    // Reset during ACK with both requests pending.
    vblank = 1'b1; mid_screen = 1'b1;
    wait_iint("reset_midop");
    vblank = 1'b0; mid_screen = 1'b0;
    cycle(1'b1);
    cycle(1'b0);
    rst = 1'b0;
    repeat (S + 3) cycle(1'b0);
    rst = 1'b1;
    repeat (10) cycle(1'b0);

    // Random traffic with a reactive CPU.
    cpu_auto = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cycle(1'b0);
      if ($urandom_range(0, 11) == 0) vblank = ~vblank;
      if ($urandom_range(0, 11) == 0) mid_screen = ~mid_screen;
    end
    vblank = 1'b0; mid_screen = 1'b0;
    repeat (80) cycle(1'b0);
    cpu_auto = 1'b0;
    ack_left = 0;
    repeat (4) cycle(1'b0);
    @(negedge clk);
    #4;

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d unchecked acks need 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
